edge_mag_arbiter: RTL and testbench
===================================

# edge_mag_arbiter

Shares one gradient-magnitude/threshold unit among four Sobel gradient lanes in the edge-detection pipeline. Each lane presents a signed 11-bit gx/gy pair with a valid/ready handshake. A round-robin arbiter grants one lane per cycle into a two-stage pipeline that computes the saturated magnitude |gx|+|gy| and compares it against a programmable threshold. Results leave with their lane tag toward the output pixel writer, with full downstream backpressure.

## Interface
- NUM_LANES, 4: number of requesting gradient lanes (fixed at 4 for this revision).
- GW, 11: gradient word width, two's complement.
- THR_RESET, 8'd150: threshold value after reset.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- lane_valid  in  4  lane i holds a valid gx/gy pair.
- lane_gx  in  4x11  per-lane signed horizontal gradient.
- lane_gy  in  4x11  per-lane signed vertical gradient.
- lane_ready  out  4  one-hot grant; a transfer occurs on lane i when lane_valid[i] and lane_ready[i] are both high.
- cfg_we  in  1  load the threshold from cfg_thr.
- cfg_thr  in  8  new threshold.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_lane  out  2  source lane of the result.
- out_mag  out  8  saturated magnitude, 0..255.
- out_edge  out  1  out_mag >= threshold.

## Operation
- **Arbitration**
  - Round-robin pointer rr_ptr (2 bits). Search order: rr_ptr, rr_ptr+1, ... mod 4.
  - The first lane with lane_valid high is granted, but only when stage 1 can accept (s1_accept, defined below).
  - lane_ready is combinational from lane_valid, rr_ptr and s1_accept. It is at most one-hot and is never high for a lane that is not valid.
  - After a transfer on lane g, rr_ptr becomes g+1 mod 4. With no transfer, rr_ptr holds.
- **Stage 1** registers the granted gx, gy and lane tag, plus s1_valid.
- **Stage 2** computes and registers the result:
  - abs values use 12-bit arithmetic: |-1024| = 1024, no overflow.
  - sum is 12 bits, maximum 2048.
  - out_mag = 255 if sum > 255, else sum[7:0].
  - out_edge = (out_mag >= thr_reg), using thr_reg as it stands in the cycle the result is loaded into stage 2.
- **Flow control**
  - s2_accept = !out_valid || out_ready.
  - s1_accept = !s1_valid || s2_accept.
  - Stage 2 loads from stage 1 when s2_accept is high. out_valid becomes s1_valid on that load.
  - While out_valid && !out_ready, out_valid, out_lane, out_mag and out_edge hold stable.
- **Threshold**
  - thr_reg loads cfg_thr on cfg_we.
  - A write in cycle N affects results loaded into stage 2 in cycle N+1 or later. A result already in stage 2 is not re-evaluated.

## Timing
- **Reset values**: rr_ptr=0, s1_valid=0, out_valid=0, out_lane=0, out_mag=0, out_edge=0, thr_reg=THR_RESET.
- **lane_ready during reset**: follows the combinational rule; no transfer is counted while rst is high.
- **Reset mid-operation**: in-flight results are discarded with no partial output, and the pointer returns to 0.
- **Latency**: a transfer in cycle N gives out_valid in cycle N+2 when unstalled.
- **Throughput**: one result per cycle when out_ready stays high.
- **Stall**:
  - One stalled cycle leaves both stages full.
  - lane_ready goes all-zero until out_ready returns.
  - No beat is dropped or duplicated.
- **Simultaneous events**: out_ready rising and a new grant in the same cycle are legal. Stage 2 takes the stage 1 beat, and stage 1 takes the new beat in that cycle.
- **cfg_we** may coincide with any traffic; a transfer and a threshold write in the same cycle are independent.

## Structure
- **Package edge_pkg**:
  - typedef grad_t (logic signed [10:0]) and lane_id_t (logic [1:0]).
  - constants MAG_MAX=255 and THR_DEFAULT=150.
- **Sub-module grad_mag_sat**: combinational; inputs gx and gy of type grad_t, output 8-bit saturated magnitude. It is used in stage 2 and is reusable by the single-lane path.
- **Arbiter logic**: the round-robin arbiter stays inline in edge_mag_arbiter.

## Test plan
- **Reset defaults**: assert rst for 2 cycles -> all outputs 0, thr_reg=150, first grant goes to lane 0 when all lanes are valid.
- **Round robin**: all 4 lanes valid continuously, out_ready=1 -> grants in order 0,1,2,3,0; out_lane follows the same order 2 cycles later.
- **Arithmetic edges**:
  - gx=-1024, gy=0 -> out_mag=255, out_edge=1.
  - gx=100, gy=-49 -> out_mag=149, out_edge=0.
  - gx=75, gy=75 -> out_mag=150, out_edge=1.
  - gx=0, gy=0 -> out_mag=0, out_edge=0.
- **Backpressure**: hold out_ready=0 for 5 cycles with lanes valid -> exactly 2 beats in flight, lane_ready=0, outputs stable. On release, results emerge in order with no loss.
- **Threshold change**: cfg_we with cfg_thr=200 in cycle N, then stream mag=180 beats -> beats loaded into stage 2 before N+1 flag 1, later beats flag 0.
- **Reset mid-stream**: pulse rst while both stages are full -> out_valid=0 on the next cycle, and the arbiter restarts at lane 0.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detection magnitude/threshold path.
package edge_pkg;

    typedef logic signed [10:0] grad_t;
    typedef logic [1:0]         lane_id_t;

    localparam int MAG_MAX     = 255;
    localparam int THR_DEFAULT = 150;

endpackage

// File: rtl/grad_mag_sat.sv
// Combinational saturated gradient magnitude |gx|+|gy|, clipped to 0..255.
module grad_mag_sat
    import edge_pkg::*;
(
    input  grad_t      gx,
    input  grad_t      gy,
    output logic [7:0] mag
);

    logic [11:0] ext_x;
    logic [11:0] ext_y;
    logic [11:0] abs_x;
    logic [11:0] abs_y;
    logic [11:0] sum;

    // One extra bit so that |-1024| = 1024 is representable and the sum cannot wrap.
    always_comb begin
        ext_x = {gx[10], gx};
        ext_y = {gy[10], gy};
        abs_x = ext_x[11] ? (~ext_x + 12'd1) : ext_x;
        abs_y = ext_y[11] ? (~ext_y + 12'd1) : ext_y;
        sum   = abs_x + abs_y;
        mag   = (sum > 12'(MAG_MAX)) ? 8'(MAG_MAX) : sum[7:0];
    end

endmodule

// File: rtl/edge_mag_arbiter.sv
// Round-robin sharing of one magnitude/threshold unit among four Sobel lanes,
// feeding a two-stage pipeline with full downstream backpressure.
module edge_mag_arbiter
    import edge_pkg::*;
#(
    parameter int         NUM_LANES = 4,
    parameter int         GW        = 11,
    parameter logic [7:0] THR_RESET = 8'(THR_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LANES-1:0]         lane_valid,
    input  logic [NUM_LANES-1:0][GW-1:0] lane_gx,
    input  logic [NUM_LANES-1:0][GW-1:0] lane_gy,
    output logic [NUM_LANES-1:0]         lane_ready,
    input  logic                         cfg_we,
    input  logic [7:0]                   cfg_thr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output lane_id_t                     out_lane,
    output logic [7:0]                   out_mag,
    output logic                         out_edge
);

    lane_id_t   rr_ptr_q;
    logic       s1_valid_q;
    grad_t      s1_gx_q;
    grad_t      s1_gy_q;
    lane_id_t   s1_lane_q;
    logic       out_valid_q;
    lane_id_t   out_lane_q;
    logic [7:0] out_mag_q;
    logic       out_edge_q;
    logic [7:0] thr_q;

    logic       s2_accept;
    logic       s1_accept;
    logic       grant_found;
    lane_id_t   grant_idx;
    lane_id_t   probe_idx;
    logic       xfer;
    logic [7:0] mag_d;
    logic       edge_d;

    assign s2_accept = !out_valid_q || out_ready;
    assign s1_accept = !s1_valid_q || s2_accept;

    // First valid lane at or after the pointer wins; the grant is withheld when stage 1 is blocked.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        probe_idx   = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            probe_idx = rr_ptr_q + lane_id_t'(k);
            if (!grant_found && lane_valid[probe_idx]) begin
                grant_found = 1'b1;
                grant_idx   = probe_idx;
            end
        end
        lane_ready = (grant_found && s1_accept) ? (NUM_LANES'(1) << grant_idx) : '0;
        xfer       = grant_found && s1_accept;
    end

    grad_mag_sat u_mag (
        .gx  (s1_gx_q),
        .gy  (s1_gy_q),
        .mag (mag_d)
    );

    assign edge_d = (mag_d >= thr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_gx_q     <= '0;
            s1_gy_q     <= '0;
            s1_lane_q   <= '0;
            out_valid_q <= 1'b0;
            out_lane_q  <= '0;
            out_mag_q   <= '0;
            out_edge_q  <= 1'b0;
            thr_q       <= THR_RESET;
        end else begin
            if (xfer) begin
                rr_ptr_q <= grant_idx + lane_id_t'(1);
            end
            if (s1_accept) begin
                s1_valid_q <= xfer;
                if (xfer) begin
                    s1_gx_q   <= lane_gx[grant_idx];
                    s1_gy_q   <= lane_gy[grant_idx];
                    s1_lane_q <= grant_idx;
                end
            end
            // Result fields only change when a real beat arrives, so a stalled result stays put.
            if (s2_accept) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_lane_q <= s1_lane_q;
                    out_mag_q  <= mag_d;
                    out_edge_q <= edge_d;
                end
            end
            if (cfg_we) begin
                thr_q <= cfg_thr;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_lane  = out_lane_q;
    assign out_mag   = out_mag_q;
    assign out_edge  = out_edge_q;

endmodule

// File: tb/tb_edge_mag_arbiter.sv
// Randomized and directed bench for edge_mag_arbiter against a transaction-level model.
module tb_edge_mag_arbiter;
    import edge_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       lane_valid;
    logic [3:0][10:0] lane_gx;
    logic [3:0][10:0] lane_gy;
    logic [3:0]       lane_ready;
    logic             cfg_we;
    logic [7:0]       cfg_thr;
    logic             out_valid;
    logic             out_ready;
    lane_id_t         out_lane;
    logic [7:0]       out_mag;
    logic             out_edge;

    edge_mag_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .lane_valid (lane_valid),
        .lane_gx    (lane_gx),
        .lane_gy    (lane_gy),
        .lane_ready (lane_ready),
        .cfg_we     (cfg_we),
        .cfg_thr    (cfg_thr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_lane   (out_lane),
        .out_mag    (out_mag),
        .out_edge   (out_edge)
    );

    always #5 clk = ~clk;

    // Each in-flight beat remembers which stage it occupies and, once in stage 2, its edge flag.
    typedef struct {
        int lane;
        int mag;
        int edgeFlag;
        int stage;
    } beat_t;

    beat_t pipe[$];
    int    rrPtr      = 0;
    int    thrModel   = 150;
    int    checkCount = 0;
    int    passCount  = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    function automatic int magOf(input logic signed [10:0] x, input logic signed [10:0] y);
        int ax;
        int ay;
        ax = (int'(x) < 0) ? -int'(x) : int'(x);
        ay = (int'(y) < 0) ? -int'(y) : int'(y);
        return (ax + ay > 255) ? 255 : ax + ay;
    endfunction

    // The pipeline holds at most two beats; a full pipeline only moves if the result is taken.
    function automatic int expectedGrant(input logic [3:0] v, input logic ordy);
        if (pipe.size() == 2 && !ordy) return -1;
        for (int k = 0; k < 4; k++) begin
            if (v[(rrPtr + k) % 4]) return (rrPtr + k) % 4;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic rstIn, input logic [3:0] v,
                                 input logic [3:0][10:0] gx, input logic [3:0][10:0] gy,
                                 input logic ordy, input logic we, input logic [7:0] thr);
        int    g;
        beat_t b;
        @(negedge clk);
        rst        = rstIn;
        lane_valid = v;
        lane_gx    = gx;
        lane_gy    = gy;
        out_ready  = ordy;
        cfg_we     = we;
        cfg_thr    = thr;
        #1;
        g = expectedGrant(v, ordy);
        if (!rstIn) begin
            checkOutput("lane_ready", int'(lane_ready), (g < 0) ? 0 : (1 << g));
            if (pipe.size() > 0 && pipe[0].stage == 2) begin
                checkOutput("out_valid", int'(out_valid), 1);
                checkOutput("out_lane", int'(out_lane), pipe[0].lane);
                checkOutput("out_mag", int'(out_mag), pipe[0].mag);
                checkOutput("out_edge", int'(out_edge), pipe[0].edgeFlag);
            end else begin
                checkOutput("out_valid", int'(out_valid), 0);
            end
        end
        @(posedge clk);
        if (rstIn) begin
            pipe.delete();
            rrPtr    = 0;
            thrModel = 150;
        end else begin
            if (pipe.size() > 0 && pipe[0].stage == 2 && ordy) void'(pipe.pop_front());
            if (pipe.size() > 0 && pipe[0].stage == 1) begin
                pipe[0].stage    = 2;
                pipe[0].edgeFlag = (pipe[0].mag >= thrModel) ? 1 : 0;
            end
            if (g >= 0) begin
                b.lane     = g;
                b.mag      = magOf(gx[g], gy[g]);
                b.stage    = 1;
                b.edgeFlag = 0;
                pipe.push_back(b);
                rrPtr = (g + 1) % 4;
            end
            if (we) thrModel = int'(thr);
        end
    endtask

    task automatic checkResetState();
        #1;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_lane", int'(out_lane), 0);
        checkOutput("rst_out_mag", int'(out_mag), 0);
        checkOutput("rst_out_edge", int'(out_edge), 0);
    endtask

    logic [3:0][10:0] arithGx;
    logic [3:0][10:0] arithGy;
    logic [3:0][10:0] rndGx;
    logic [3:0][10:0] rndGy;
    logic [3:0][10:0] flatGx;
    logic [3:0][10:0] flatGy;

    initial begin
        rst        = 1'b1;
        lane_valid = '0;
        lane_gx    = '0;
        lane_gy    = '0;
        out_ready  = 1'b1;
        cfg_we     = 1'b0;
        cfg_thr    = '0;

        // Lanes 0..3 carry the arithmetic corner cases: 255/edge, 149/no, 150/edge, 0/no.
        arithGx = {11'sd0, 11'sd75, 11'sd100, -11'sd1024};
        arithGy = {11'sd0, 11'sd75, -11'sd49, 11'sd0};
        flatGx  = {4{11'sd90}};
        flatGy  = {4{11'sd90}};

        repeat (2) applyStimulus(1'b1, 4'h0, arithGx, arithGy, 1'b1, 1'b0, 8'd0);
        checkResetState();

        repeat (10) applyStimulus(1'b0, 4'hF, arithGx, arithGy, 1'b1, 1'b0, 8'd0);

        repeat (5) applyStimulus(1'b0, 4'hF, arithGx, arithGy, 1'b0, 1'b0, 8'd0);
        repeat (6) applyStimulus(1'b0, 4'hF, arithGx, arithGy, 1'b1, 1'b0, 8'd0);

        repeat (2) applyStimulus(1'b0, 4'hF, flatGx, flatGy, 1'b1, 1'b0, 8'd0);
        applyStimulus(1'b0, 4'hF, flatGx, flatGy, 1'b1, 1'b1, 8'd200);
        repeat (5) applyStimulus(1'b0, 4'hF, flatGx, flatGy, 1'b1, 1'b0, 8'd0);

        repeat (3) applyStimulus(1'b0, 4'hF, arithGx, arithGy, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 4'hF, arithGx, arithGy, 1'b0, 1'b0, 8'd0);
        checkResetState();
        repeat (4) applyStimulus(1'b0, 4'hF, arithGx, arithGy, 1'b1, 1'b0, 8'd0);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rndGx[i] = 11'($urandom_range(0, 255)) - 11'sd128;
                    rndGy[i] = 11'($urandom_range(0, 255)) - 11'sd128;
                end else begin
                    rndGx[i] = 11'($urandom);
                    rndGy[i] = 11'($urandom);
                end
            end
            applyStimulus(1'b0, 4'($urandom), rndGx, rndGy, ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 15) == 0), 8'($urandom));
        end

        repeat (4) applyStimulus(1'b0, 4'h0, arithGx, arithGy, 1'b1, 1'b0, 8'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
